// File: rtl/lsb_queue.sv
// In-order load/store queue: tracks operands by ROB tag, issues one memory request at a time
// from the head and broadcasts load results. Committed stores survive a rollback.
module lsb_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROB_W   = 4,
  parameter logic [31:0] IO_MASK = 32'h0003_0000,
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  output logic             lsb_full,
  input  logic             inst_valid,
  input  logic             inst_is_store,
  input  logic [2:0]       inst_precise,
  input  logic [ROB_W-1:0] inst_rob,
  input  logic [31:0]      inst_rs1_val,
  input  logic [31:0]      inst_rs2_val,
  input  logic             inst_rs1_wait,
  input  logic             inst_rs2_wait,
  input  logic [ROB_W-1:0] inst_rs1_tag,
  input  logic [ROB_W-1:0] inst_rs2_tag,
  input  logic [31:0]      inst_imm,
  input  logic             cdb0_valid,
  input  logic [ROB_W-1:0] cdb0_rob,
  input  logic [31:0]      cdb0_value,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb1_rob,
  input  logic [31:0]      cdb1_value,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob,
  input  logic [ROB_W-1:0] rob_head,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_precise,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             bc_valid,
  output logic [ROB_W-1:0] bc_rob,
  output logic [31:0]      bc_value
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic             is_store;
    logic [2:0]       precise;
    logic [ROB_W-1:0] rob;
    logic [31:0]      base_val;
    logic             base_wait;
    logic [ROB_W-1:0] base_tag;
    logic [31:0]      data_val;
    logic             data_wait;
    logic [ROB_W-1:0] data_tag;
    logic [31:0]      imm;
    logic             committed;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  state_e          state_q, state_d;
  logic [PW-1:0]   enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]   deq_ptr_q, deq_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            req_d, we_d, bcv_d;
  logic [31:0]     addr_d, wdata_d, bcval_d;
  logic [2:0]      prec_d;
  logic [ROB_W-1:0] bcrob_d;

  logic [PW-1:0]   offs [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CW-1:0]   cc;
  logic            run;
  logic [PW-1:0]   idx;

  entry_t          head;
  entry_t          new_ent;
  logic [31:0]     head_addr;
  logic            head_io;
  logic            can_issue;
  logic            enq_fire;
  logic            retire;

  assign lsb_full  = (count_q == CW'(DEPTH));
  assign head      = ent_q[deq_ptr_q];
  assign head_addr = head.base_val + head.imm;
  assign head_io   = ((head_addr & IO_MASK) == IO_BASE);

  always_comb begin
    can_issue = 1'b0;
    if (count_q != '0 && !head.base_wait) begin
      if (head.is_store) begin
        can_issue = !head.data_wait && head.committed;
      end else begin
        // IO loads have side effects, so they wait until non-speculative
        can_issue = !head_io || (head.rob == rob_head);
      end
    end
  end

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs[i]  = PW'(i) - deq_ptr_q;
      valid[i] = ({1'b0, offs[i]} < count_q);
    end
  end

  // Length of the committed-store run starting at the head
  always_comb begin
    cc  = '0;
    run = 1'b1;
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = deq_ptr_q + PW'(i);
      if (run && valid[idx] && ent_q[idx].committed) begin
        cc = cc + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Incoming entry with same-cycle bus bypass
  always_comb begin
    new_ent           = '0;
    new_ent.is_store  = inst_is_store;
    new_ent.precise   = inst_precise;
    new_ent.rob       = inst_rob;
    new_ent.imm       = inst_imm;
    new_ent.base_val  = inst_rs1_val;
    new_ent.base_wait = inst_rs1_wait;
    new_ent.base_tag  = inst_rs1_tag;
    new_ent.data_val  = inst_rs2_val;
    new_ent.data_wait = inst_rs2_wait && inst_is_store;
    new_ent.data_tag  = inst_rs2_tag;
    if (new_ent.base_wait) begin
      if (cdb0_valid && cdb0_rob == inst_rs1_tag) begin
        new_ent.base_val  = cdb0_value;
        new_ent.base_wait = 1'b0;
      end else if (cdb1_valid && cdb1_rob == inst_rs1_tag) begin
        new_ent.base_val  = cdb1_value;
        new_ent.base_wait = 1'b0;
      end
    end
    if (new_ent.data_wait) begin
      if (cdb0_valid && cdb0_rob == inst_rs2_tag) begin
        new_ent.data_val  = cdb0_value;
        new_ent.data_wait = 1'b0;
      end else if (cdb1_valid && cdb1_rob == inst_rs2_tag) begin
        new_ent.data_val  = cdb1_value;
        new_ent.data_wait = 1'b0;
      end
    end
  end

  always_comb begin
    ent_d     = ent_q;
    state_d   = state_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    req_d     = mem_req;
    we_d      = mem_we;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    prec_d    = mem_precise;
    bcv_d     = 1'b0;
    bcrob_d   = bc_rob;
    bcval_d   = bc_value;
    retire    = 1'b0;
    enq_fire  = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        if (ent_q[i].base_wait) begin
          if (cdb0_valid && cdb0_rob == ent_q[i].base_tag) begin
            ent_d[i].base_val  = cdb0_value;
            ent_d[i].base_wait = 1'b0;
          end else if (cdb1_valid && cdb1_rob == ent_q[i].base_tag) begin
            ent_d[i].base_val  = cdb1_value;
            ent_d[i].base_wait = 1'b0;
          end
        end
        if (ent_q[i].data_wait) begin
          if (cdb0_valid && cdb0_rob == ent_q[i].data_tag) begin
            ent_d[i].data_val  = cdb0_value;
            ent_d[i].data_wait = 1'b0;
          end else if (cdb1_valid && cdb1_rob == ent_q[i].data_tag) begin
            ent_d[i].data_val  = cdb1_value;
            ent_d[i].data_wait = 1'b0;
          end
        end
        if (!rollback && commit_valid && ent_q[i].is_store && ent_q[i].rob == commit_rob) begin
          ent_d[i].committed = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (!rollback && can_issue) begin
          state_d = StBusy;
          req_d   = 1'b1;
          we_d    = head.is_store;
          addr_d  = head_addr;
          wdata_d = head.data_val;
          prec_d  = head.precise;
        end
      end
      StBusy: begin
        if (mem_done) begin
          req_d   = 1'b0;
          state_d = StIdle;
          if (mem_we) begin
            retire = 1'b1;
          end else if (!rollback) begin
            retire  = 1'b1;
            bcv_d   = 1'b1;
            bcrob_d = head.rob;
            bcval_d = mem_rdata;
          end
        end else if (rollback && !mem_we) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (mem_done) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rollback) begin
      // An in-flight committed store may retire in this same cycle
      enq_ptr_d = deq_ptr_q + cc[PW-1:0];
      deq_ptr_d = deq_ptr_q + PW'(retire);
      count_d   = cc - CW'(retire);
    end else begin
      enq_fire = inst_valid && !lsb_full;
      if (enq_fire) begin
        ent_d[enq_ptr_q] = new_ent;
        enq_ptr_d        = enq_ptr_q + PW'(1);
      end
      deq_ptr_d = deq_ptr_q + PW'(retire);
      count_d   = count_q + CW'(enq_fire) - CW'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      enq_ptr_q   <= '0;
      deq_ptr_q   <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_precise <= '0;
      bc_valid    <= 1'b0;
      bc_rob      <= '0;
      bc_value    <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      enq_ptr_q   <= enq_ptr_d;
      deq_ptr_q   <= deq_ptr_d;
      count_q     <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      mem_req     <= req_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      mem_precise <= prec_d;
      bc_valid    <= bcv_d;
      bc_rob      <= bcrob_d;
      bc_value    <= bcval_d;
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed self-checking bench for lsb_queue with DEPTH=8: load/store issue, full, rollback,
// IO gating and enqueue bypass.
module tb_lsb_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ROB_W = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, rollback;
  logic             lsb_full;
  logic             inst_valid, inst_is_store;
  logic [2:0]       inst_precise;
  logic [ROB_W-1:0] inst_rob;
  logic [31:0]      inst_rs1_val, inst_rs2_val;
  logic             inst_rs1_wait, inst_rs2_wait;
  logic [ROB_W-1:0] inst_rs1_tag, inst_rs2_tag;
  logic [31:0]      inst_imm;
  logic             cdb0_valid, cdb1_valid;
  logic [ROB_W-1:0] cdb0_rob, cdb1_rob;
  logic [31:0]      cdb0_value, cdb1_value;
  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob, rob_head;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic [2:0]       mem_precise;
  logic             mem_done;
  logic [31:0]      mem_rdata;
  logic             bc_valid;
  logic [ROB_W-1:0] bc_rob;
  logic [31:0]      bc_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .lsb_full(lsb_full),
    .inst_valid(inst_valid), .inst_is_store(inst_is_store), .inst_precise(inst_precise),
    .inst_rob(inst_rob), .inst_rs1_val(inst_rs1_val), .inst_rs2_val(inst_rs2_val),
    .inst_rs1_wait(inst_rs1_wait), .inst_rs2_wait(inst_rs2_wait),
    .inst_rs1_tag(inst_rs1_tag), .inst_rs2_tag(inst_rs2_tag), .inst_imm(inst_imm),
    .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_value(cdb1_value),
    .commit_valid(commit_valid), .commit_rob(commit_rob), .rob_head(rob_head),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_precise(mem_precise), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .bc_valid(bc_valid), .bc_rob(bc_rob), .bc_value(bc_value)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic st, input logic [ROB_W-1:0] rob,
                         input logic [31:0] v1, input logic w1, input logic [ROB_W-1:0] t1,
                         input logic [31:0] v2, input logic w2, input logic [ROB_W-1:0] t2,
                         input logic [31:0] imm);
    inst_valid    = 1'b1;
    inst_is_store = st;
    inst_precise  = 3'b010;
    inst_rob      = rob;
    inst_rs1_val  = v1;
    inst_rs1_wait = w1;
    inst_rs1_tag  = t1;
    inst_rs2_val  = v2;
    inst_rs2_wait = w2;
    inst_rs2_tag  = t2;
    inst_imm      = imm;
    tick();
    inst_valid    = 1'b0;
  endtask

  task automatic complete(input logic [31:0] rdata);
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    check(tag, 32'(mem_req), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    inst_valid = 1'b0; inst_is_store = 1'b0; inst_precise = 3'b0; inst_rob = '0;
    inst_rs1_val = '0; inst_rs2_val = '0; inst_rs1_wait = 1'b0; inst_rs2_wait = 1'b0;
    inst_rs1_tag = '0; inst_rs2_tag = '0; inst_imm = '0;
    cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_value = '0;
    cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_value = '0;
    commit_valid = 1'b0; commit_rob = '0; rob_head = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_bc_valid", 32'(bc_valid), 32'd0);
    check("rst_full", 32'(lsb_full), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);

    // Load: issue one cycle after enqueue, broadcast one cycle after mem_done
    enqueue(1'b0, 4'd3, 32'h100, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'd4);
    check("ld_no_req_yet", 32'(mem_req), 32'd0);
    tick();
    check("ld_req", 32'(mem_req), 32'd1);
    check("ld_addr", mem_addr, 32'h104);
    check("ld_we", 32'(mem_we), 32'd0);
    complete(32'hDEADBEEF);
    check("ld_req_drop", 32'(mem_req), 32'd0);
    check("ld_bc_valid", 32'(bc_valid), 32'd1);
    check("ld_bc_rob", 32'(bc_rob), 32'd3);
    check("ld_bc_value", bc_value, 32'hDEADBEEF);
    tick();
    check("ld_bc_pulse", 32'(bc_valid), 32'd0);

    // Store: data woken by cdb0, then held until commit
    enqueue(1'b1, 4'd5, 32'h200, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'd0);
    tick();
    check("st_wait_data", 32'(mem_req), 32'd0);
    cdb0_valid = 1'b1; cdb0_rob = 4'd7; cdb0_value = 32'h55;
    tick();
    cdb0_valid = 1'b0;
    tick(); tick();
    check("st_wait_commit", 32'(mem_req), 32'd0);
    commit_valid = 1'b1; commit_rob = 4'd5;
    tick();
    commit_valid = 1'b0;
    check("st_no_req_commit_edge", 32'(mem_req), 32'd0);
    tick();
    check("st_req", 32'(mem_req), 32'd1);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_wdata", mem_wdata, 32'h55);
    check("st_addr", mem_addr, 32'h200);
    complete(32'h0);
    check("st_no_bc", 32'(bc_valid), 32'd0);
    check("st_count", 32'(dut.count_q), 32'd0);

    // Fill with base-waiting loads, then drain
    for (int i = 0; i < DEPTH; i++)
      enqueue(1'b0, 4'(i), 32'h0, 1'b1, 4'd10, 32'h0, 1'b0, 4'd0, 32'(4 * i));
    check("full_flag", 32'(lsb_full), 32'd1);
    check("full_count", 32'(dut.count_q), 32'd8);
    enqueue(1'b0, 4'd15, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    check("full_drop_count", 32'(dut.count_q), 32'd8);
    check("full_drop_enq", 32'(dut.enq_ptr_q), 32'd2);
    check("full_no_issue", 32'(mem_req), 32'd0);
    cdb0_valid = 1'b1; cdb0_rob = 4'd10; cdb0_value = 32'h1000;
    tick();
    cdb0_valid = 1'b0;
    wait_req("drain0_req");
    check("drain0_addr", mem_addr, 32'h1000);
    // Retire and enqueue together while full: enqueue refused
    inst_valid = 1'b1; inst_is_store = 1'b0; inst_rob = 4'd14; inst_rs1_wait = 1'b0;
    complete(32'h0);
    inst_valid = 1'b0;
    check("full_retire_count", 32'(dut.count_q), 32'd7);
    check("drain0_bc_rob", 32'(bc_rob), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      wait_req("drain_req");
      check("drain_addr", mem_addr, 32'h1000 + 32'(4 * i));
      complete(32'(i));
      check("drain_bc_rob", 32'(bc_rob), 32'(i));
    end
    tick(); tick();
    check("drain_extra_gone", 32'(mem_req), 32'd0);
    check("drain_count", 32'(dut.count_q), 32'd0);
    check("drain_deq", 32'(dut.deq_ptr_q), 32'd2);
    check("drain_enq", 32'(dut.enq_ptr_q), 32'd2);

    // Rollback with a load in flight: DROP, response discarded
    enqueue(1'b0, 4'd1, 32'h300, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'd0);
    enqueue(1'b0, 4'd2, 32'h304, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'd0);
    check("drop_busy", 32'(mem_req), 32'd1);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    check("drop_state", 32'(dut.state_q), 32'd2);
    check("drop_enq", 32'(dut.enq_ptr_q), 32'd2);
    check("drop_count", 32'(dut.count_q), 32'd0);
    complete(32'h1234);
    check("drop_no_bc", 32'(bc_valid), 32'd0);
    check("drop_idle", 32'(dut.state_q), 32'd0);
    check("drop_req_low", 32'(mem_req), 32'd0);
    tick();
    check("drop_no_reissue", 32'(mem_req), 32'd0);

    // Rollback keeps the committed-store run; store in flight completes
    enqueue(1'b1, 4'd4, 32'h400, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'd0);
    enqueue(1'b1, 4'd5, 32'h404, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0, 32'd0);
    commit_valid = 1'b1; commit_rob = 4'd4;
    tick();
    commit_rob = 4'd5;
    tick();
    commit_valid = 1'b0;
    check("rb_st0_req", 32'(mem_req), 32'd1);
    check("rb_st0_addr", mem_addr, 32'h400);
    for (int i = 0; i < 3; i++)
      enqueue(1'b0, 4'(8 + i), 32'h0, 1'b1, 4'd12, 32'h0, 1'b0, 4'd0, 32'd0);
    check("rb_pre_count", 32'(dut.count_q), 32'd5);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    check("rb_state_busy", 32'(dut.state_q), 32'd1);
    check("rb_enq", 32'(dut.enq_ptr_q), 32'd4);
    check("rb_count", 32'(dut.count_q), 32'd2);
    complete(32'h0);
    check("rb_st0_no_bc", 32'(bc_valid), 32'd0);
    check("rb_st0_count", 32'(dut.count_q), 32'd1);
    wait_req("rb_st1_req");
    check("rb_st1_addr", mem_addr, 32'h404);
    check("rb_st1_wdata", mem_wdata, 32'hB);
    check("rb_st1_we", 32'(mem_we), 32'd1);
    complete(32'h0);
    check("rb_final_count", 32'(dut.count_q), 32'd0);
    check("rb_final_deq", 32'(dut.deq_ptr_q), 32'd4);

    // IO load waits for rob_head
    rob_head = 4'd8;
    enqueue(1'b0, 4'd9, 32'h30000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'd0);
    tick(); tick();
    check("io_held", 32'(mem_req), 32'd0);
    rob_head = 4'd9;
    tick();
    check("io_req", 32'(mem_req), 32'd1);
    check("io_addr", mem_addr, 32'h30000);
    complete(32'h77);
    check("io_bc_rob", 32'(bc_rob), 32'd9);
    check("io_bc_value", bc_value, 32'h77);

    // Enqueue bypass from cdb1
    tick();
    cdb1_valid = 1'b1; cdb1_rob = 4'd2; cdb1_value = 32'h200;
    enqueue(1'b0, 4'd6, 32'h0, 1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'h10);
    cdb1_valid = 1'b0;
    tick();
    check("byp_req", 32'(mem_req), 32'd1);
    check("byp_addr", mem_addr, 32'h210);
    complete(32'h5);
    check("byp_bc_rob", 32'(bc_rob), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
